// File: rtl/gerador_jogadas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gerador_jogadas_pkg
// Purpose  : Shared definitions for the hardware memory-game player: FSM
//            state encodings (also the 7-segment debug codes) and datapath
//            widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gerador_jogadas_pkg;

  // Width of the one-hot key vector driven into the game
  localparam int c_chave_w    = 4;
  // Width of the ROM address / play index
  localparam int c_end_w      = 4;
  // Largest number of plays a sequence can hold
  localparam int c_max_jogadas = 16;

  // Encodings double as the db_estado display codes
  typedef enum logic [3:0] {
    ST_INICIAL   = 4'h0,
    ST_CARREGA   = 4'h1,
    ST_PRESSIONA = 4'h2,
    ST_SOLTA     = 4'h3,
    ST_PROXIMA   = 4'h4,
    ST_FIM       = 4'hF
  } estado_t;

  // Rotate-left by one; a zero play becomes 4'b0001 so the corrupted play
  // always differs from the expected one.
  function automatic logic [c_chave_w-1:0] corrompe(input logic [c_chave_w-1:0] v);
    logic [c_chave_w-1:0] r;
    r = {v[c_chave_w-2:0], v[c_chave_w-1]};
    if (v == '0) begin
      r = {{(c_chave_w-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gerador_jogadas_contador_timer.sv
`default_nettype none
// ============================================================================
// Module   : contador_timer
// Purpose  : Generic modulo-M counter with synchronous clear and enable. The
//            terminal value is supplied at run time so one instance can time
//            phases of different lengths (up to M cycles).
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            i_clr    - synchronous clear (count returns to 0)
//            i_en     - count enable
//            i_term   - terminal count; the counter wraps to 0 after it
//            o_fim    - high while enabled and the count equals i_term
// Revision : 1.0 - initial release
// ============================================================================
module contador_timer #(
  parameter int M = 10,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_fim
);

  logic [W-1:0] r_cont;
  logic         w_topo;

  // Wrap either at the selected terminal value or at the modulus itself
  assign w_topo = (r_cont == i_term) || (r_cont == W'(M - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cont <= '0;
    end else if (i_en) begin
      r_cont <= w_topo ? '0 : r_cont + W'(1);
    end
  end

  assign o_fim = i_en && (r_cont == i_term);

endmodule
`default_nettype wire

// File: rtl/gerador_jogadas.sv
`default_nettype none
// ============================================================================
// Module   : gerador_jogadas
// Purpose  : Hardware player for the memory game. Reads each expected play
//            from the sequence ROM, presses it on `chaves` for HOLD_CYCLES,
//            releases for GAP_CYCLES, and moves to the next play. Stops after
//            the current play when the game flags acertou/errou. One play
//            can optionally be corrupted to exercise the game's error path.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            iniciar           - start request (accepted in INICIAL or FIM)
//            num_jogadas[4:0]  - plays to perform (0..16, larger saturates)
//            jogada_rom[3:0]   - ROM data at endereco
//            acertou, errou    - game outcome flags
//            injeta_erro       - corrupt play erro_idx (latched at start)
//            erro_idx[3:0]     - index of the play to corrupt
//            chaves[3:0]       - key vector to the game
//            endereco[3:0]     - ROM address / current play index
//            ocupado           - sequence in progress
//            pronto            - sequence finished (FIM)
//            db_estado[3:0]    - state code for the debug display
// Revision : 1.0 - initial release
// ============================================================================
module gerador_jogadas
  import gerador_jogadas_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [4:0]           num_jogadas,
  input  logic [c_chave_w-1:0] jogada_rom,
  input  logic                 acertou,
  input  logic                 errou,
  input  logic                 injeta_erro,
  input  logic [c_end_w-1:0]   erro_idx,
  output logic [c_chave_w-1:0] chaves,
  output logic [c_end_w-1:0]   endereco,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [3:0]           db_estado
);

  localparam int c_timer_m = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_timer_w = (c_timer_m > 1) ? $clog2(c_timer_m) : 1;

  estado_t                r_estado;
  estado_t                w_prox;
  logic [c_chave_w-1:0]   r_registro;
  logic [c_end_w-1:0]     r_endereco;
  logic [4:0]             r_limite;
  logic                   r_fim_jogo;
  logic                   r_injeta;
  logic [c_end_w-1:0]     r_erro_idx;

  logic                   w_aceita;
  logic                   w_ocupado;
  logic                   w_ultima;
  logic                   w_encerra;
  logic [4:0]             w_limite;
  logic [c_chave_w-1:0]   w_jogada;
  logic                   w_t_clr;
  logic                   w_t_en;
  logic [c_timer_w-1:0]   w_t_term;
  logic                   w_t_fim;

  assign w_ocupado = (r_estado == ST_CARREGA) || (r_estado == ST_PRESSIONA) ||
                     (r_estado == ST_SOLTA)   || (r_estado == ST_PROXIMA);

  // Start is only honoured while idle or finished
  assign w_aceita  = iniciar && ((r_estado == ST_INICIAL) || (r_estado == ST_FIM));

  assign w_limite  = (num_jogadas > 5'(c_max_jogadas)) ? 5'(c_max_jogadas) : num_jogadas;

  // r_limite is at least 1 whenever SOLTA is reachable
  assign w_ultima  = ({1'b0, r_endereco} == (r_limite - 5'd1));

  // An outcome flag seen during the last gap cycle also ends the sequence
  assign w_encerra = r_fim_jogo || acertou || errou || w_ultima;

  assign w_jogada  = (r_injeta && (r_endereco == r_erro_idx)) ? corrompe(jogada_rom)
                                                               : jogada_rom;

  // ---------------------------------------------------------------- timer
  assign w_t_clr  = (r_estado == ST_CARREGA);
  assign w_t_en   = (r_estado == ST_PRESSIONA) || (r_estado == ST_SOLTA);
  assign w_t_term = (r_estado == ST_PRESSIONA) ? c_timer_w'(HOLD_CYCLES - 1)
                                               : c_timer_w'(GAP_CYCLES - 1);

  contador_timer #(
    .M (c_timer_m),
    .W (c_timer_w)
  ) u_timer (
    .clk    (clock),
    .rst    (reset),
    .i_clr  (w_t_clr),
    .i_en   (w_t_en),
    .i_term (w_t_term),
    .o_fim  (w_t_fim)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_INICIAL, ST_FIM: begin
        if (iniciar) begin
          w_prox = (num_jogadas == 5'd0) ? ST_FIM : ST_CARREGA;
        end
      end
      ST_CARREGA:   w_prox = ST_PRESSIONA;
      ST_PRESSIONA: begin
        if (w_t_fim) begin
          w_prox = ST_SOLTA;
        end
      end
      ST_SOLTA: begin
        if (w_t_fim) begin
          w_prox = w_encerra ? ST_FIM : ST_PROXIMA;
        end
      end
      ST_PROXIMA:   w_prox = ST_CARREGA;
      default:      w_prox = ST_INICIAL;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_registro <= '0;
      r_endereco <= '0;
      r_limite   <= '0;
      r_fim_jogo <= 1'b0;
      r_injeta   <= 1'b0;
      r_erro_idx <= '0;
    end else if (w_aceita) begin
      r_endereco <= '0;
      r_limite   <= w_limite;
      r_fim_jogo <= 1'b0;
      r_injeta   <= injeta_erro;
      r_erro_idx <= erro_idx;
    end else begin
      if (w_ocupado && (acertou || errou)) begin
        r_fim_jogo <= 1'b1;
      end
      if (r_estado == ST_CARREGA) begin
        r_registro <= w_jogada;
      end
      if (r_estado == ST_PROXIMA) begin
        r_endereco <= r_endereco + c_end_w'(1);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Both terms are registered, so chaves is glitch-free
  assign chaves    = (r_estado == ST_PRESSIONA) ? r_registro : '0;
  assign endereco  = r_endereco;
  assign ocupado   = w_ocupado;
  assign pronto    = (r_estado == ST_FIM);
  assign db_estado = r_estado;

endmodule
`default_nettype wire
